// File: rtl/cbd_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cbd_mem_pkg : shared types for the line-fill memory arbiter         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cbd_mem_pkg;

  localparam int PA_WIDTH_DEF   = 32;
  localparam int LINE_WIDTH_DEF = 256;
  localparam int ID_WIDTH_DEF   = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IC   = 2'd1,
    ARB_DC   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } id_entry_t;

  localparam id_entry_t ENTRY_NONE = '{valid: 1'b0, owner: OWN_IC};

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter_if : one cache-side memory port; i_/o_ named from the   |
// | arbiter's point of view. Rev 1.0                                   |
// +--------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int PA_WIDTH   = 32,
  parameter int LINE_WIDTH = 256,
  parameter int ID_WIDTH   = 3
);
  logic                  i_enable;
  logic [PA_WIDTH-1:0]   i_addr;
  logic                  i_ack;
  logic                  o_enable;
  logic [LINE_WIDTH-1:0] o_data;
  logic [ID_WIDTH-1:0]   o_id_request;
  logic [ID_WIDTH-1:0]   o_id_response;
  logic                  o_in_use;

  modport master (
    output i_enable, i_addr, i_ack,
    input  o_enable, o_data, o_id_request, o_id_response, o_in_use
  );

  modport slave (
    input  i_enable, i_addr, i_ack,
    output o_enable, o_data, o_id_request, o_id_response, o_in_use
  );
endinterface
`default_nettype wire

// File: rtl/mem_id_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_id_table : per-ID ownership table with outstanding count        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_id_table
  import cbd_mem_pkg::*;
#(
  parameter int ID_WIDTH = ID_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_set_en,
  input  logic [ID_WIDTH-1:0] i_set_id,
  input  owner_t              i_set_owner,
  input  logic                i_clr_en,
  input  logic [ID_WIDTH-1:0] i_clr_id,
  input  logic [ID_WIDTH-1:0] i_req_id,
  output logic                o_req_busy,
  input  logic [ID_WIDTH-1:0] i_rsp_id,
  output id_entry_t           o_rsp_entry,
  output logic [ID_WIDTH:0]   o_count
);

  localparam int DEPTH = 1 << ID_WIDTH;
  localparam logic [ID_WIDTH:0] c_count_one = {{ID_WIDTH{1'b0}}, 1'b1};

  id_entry_t             table_q [DEPTH];
  id_entry_t             table_d [DEPTH];
  logic [ID_WIDTH:0]     count_q;
  logic [ID_WIDTH:0]     count_d;

  // Set is applied after clear so a same-ID collision leaves the new owner valid.
  always_comb begin
    table_d = table_q;
    if (i_clr_en) table_d[i_clr_id].valid = 1'b0;
    if (i_set_en) table_d[i_set_id] = '{valid: 1'b1, owner: i_set_owner};
  end

  always_comb begin
    count_d = count_q;
    case ({i_set_en, i_clr_en})
      2'b10:   count_d = count_q + c_count_one;
      2'b01:   count_d = count_q - c_count_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= ENTRY_NONE;
      count_q <= '0;
    end else begin
      table_q <= table_d;
      count_q <= count_d;
    end
  end

  assign o_req_busy  = table_q[i_req_id].valid;
  assign o_rsp_entry = table_q[i_rsp_id];
  assign o_count     = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter : round-robin share of the line-fill port between ica   |
// | and dca, with tagged response routing. Rev 1.0                     |
// +--------------------------------------------------------------------+
module mem_arbiter
  import cbd_mem_pkg::*;
#(
  parameter int PA_WIDTH   = PA_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          ic,
  mem_arbiter_if.slave          dc,
  output logic                  o_mem_enable,
  output logic [PA_WIDTH-1:0]   o_mem_addr,
  output logic                  o_mem_ack,
  input  logic                  i_mem_enable,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic [ID_WIDTH-1:0]   i_mem_id_request,
  input  logic [ID_WIDTH-1:0]   i_mem_id_response,
  input  logic                  i_mem_in_use,
  output logic [ID_WIDTH:0]     o_outstanding,
  output logic                  o_err_orphan
);

  arb_state_t state_q;
  owner_t     last_win_q;
  logic       err_q;

  logic       grant_ic;
  logic       grant_dc;
  logic       granted_en;
  logic       id_busy;
  logic       accept;
  logic       hit;
  logic       orphan;
  owner_t     grant_owner;
  id_entry_t  rsp_entry;

  // Outputs are gated by rst so they are already quiet before the first reset edge.
  assign grant_ic    = !rst && (state_q == ARB_IC);
  assign grant_dc    = !rst && (state_q == ARB_DC);
  assign grant_owner = grant_dc ? OWN_DC : OWN_IC;
  assign granted_en  = (grant_ic && ic.i_enable) || (grant_dc && dc.i_enable);

  assign o_mem_enable = granted_en && !id_busy;
  assign o_mem_addr   = grant_dc ? dc.i_addr : ic.i_addr;
  assign accept       = o_mem_enable && !i_mem_in_use;

  assign ic.o_in_use = !(grant_ic && !id_busy && !i_mem_in_use);
  assign dc.o_in_use = !(grant_dc && !id_busy && !i_mem_in_use);

  assign hit    = !rst && i_mem_enable && rsp_entry.valid;
  assign orphan = i_mem_enable && !rsp_entry.valid;

  assign ic.o_enable = hit && (rsp_entry.owner == OWN_IC);
  assign dc.o_enable = hit && (rsp_entry.owner == OWN_DC);
  assign o_mem_ack   = (ic.o_enable && ic.i_ack) || (dc.o_enable && dc.i_ack);

  assign ic.o_data        = i_mem_data;
  assign dc.o_data        = i_mem_data;
  assign ic.o_id_request  = i_mem_id_request;
  assign dc.o_id_request  = i_mem_id_request;
  assign ic.o_id_response = i_mem_id_response;
  assign dc.o_id_response = i_mem_id_response;

  assign o_err_orphan = err_q;

  mem_id_table #(
    .ID_WIDTH (ID_WIDTH)
  ) u_id_table (
    .clk         (clk),
    .rst         (rst),
    .i_set_en    (accept),
    .i_set_id    (i_mem_id_request),
    .i_set_owner (grant_owner),
    .i_clr_en    (o_mem_ack),
    .i_clr_id    (i_mem_id_response),
    .i_req_id    (i_mem_id_request),
    .o_req_busy  (id_busy),
    .i_rsp_id    (i_mem_id_response),
    .o_rsp_entry (rsp_entry),
    .o_count     (o_outstanding)
  );

  // Grant is held until the request is accepted or withdrawn; ties go to the last loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      last_win_q <= OWN_DC;
      err_q      <= 1'b0;
    end else begin
      if (orphan) err_q <= 1'b1;
      case (state_q)
        ARB_IDLE: begin
          if (ic.i_enable && dc.i_enable)
            state_q <= (last_win_q == OWN_DC) ? ARB_IC : ARB_DC;
          else if (ic.i_enable)
            state_q <= ARB_IC;
          else if (dc.i_enable)
            state_q <= ARB_DC;
        end
        ARB_IC: begin
          if (accept) begin
            state_q    <= ARB_IDLE;
            last_win_q <= OWN_IC;
          end else if (!ic.i_enable) begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_DC: begin
          if (accept) begin
            state_q    <= ARB_IDLE;
            last_win_q <= OWN_DC;
          end else if (!dc.i_enable) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_arbiter : directed + randomized check against a behavioural  |
// | model of the arbiter. Rev 1.0                                      |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int PAW = 32;
  localparam int LW  = 256;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           o_mem_enable;
  logic [PAW-1:0] o_mem_addr;
  logic           o_mem_ack;
  logic           i_mem_enable;
  logic [LW-1:0]  i_mem_data;
  logic [IDW-1:0] i_mem_id_request;
  logic [IDW-1:0] i_mem_id_response;
  logic           i_mem_in_use;
  logic [IDW:0]   o_outstanding;
  logic           o_err_orphan;

  mem_arbiter_if #(.PA_WIDTH(PAW), .LINE_WIDTH(LW), .ID_WIDTH(IDW)) ic_if ();
  mem_arbiter_if #(.PA_WIDTH(PAW), .LINE_WIDTH(LW), .ID_WIDTH(IDW)) dc_if ();

  mem_arbiter #(.PA_WIDTH(PAW), .LINE_WIDTH(LW), .ID_WIDTH(IDW)) dut (
    .clk               (clk),
    .rst               (rst),
    .ic                (ic_if),
    .dc                (dc_if),
    .o_mem_enable      (o_mem_enable),
    .o_mem_addr        (o_mem_addr),
    .o_mem_ack         (o_mem_ack),
    .i_mem_enable      (i_mem_enable),
    .i_mem_data        (i_mem_data),
    .i_mem_id_request  (i_mem_id_request),
    .i_mem_id_response (i_mem_id_response),
    .i_mem_in_use      (i_mem_in_use),
    .o_outstanding     (o_outstanding),
    .o_err_orphan      (o_err_orphan)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: grant side 0=none 1=ic 2=dc, owners 1=ic 2=dc.
  int m_gnt  = 0;
  int m_last = 2;
  bit m_valid [8];
  int m_owner [8];
  bit m_err  = 1'b0;
  bit started = 1'b0;

  function automatic bit side_en(int s);
    return (s == 1) ? ic_if.i_enable : (s == 2) ? dc_if.i_enable : 1'b0;
  endfunction

  function automatic bit f_mem_en();
    return !rst && (m_gnt != 0) && side_en(m_gnt) && !m_valid[i_mem_id_request];
  endfunction

  function automatic bit f_in_use(int s);
    return !(!rst && (m_gnt == s) && !m_valid[i_mem_id_request] && !i_mem_in_use);
  endfunction

  function automatic bit f_route(int s);
    return !rst && i_mem_enable && m_valid[i_mem_id_response] &&
           (m_owner[i_mem_id_response] == s);
  endfunction

  function automatic bit f_ack();
    return (f_route(1) && ic_if.i_ack) || (f_route(2) && dc_if.i_ack);
  endfunction

  function automatic int f_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  always @(posedge clk) begin
    bit acc, ack, orph;
    int g, rq, rs;
    started = 1'b1;
    if (rst) begin
      m_gnt = 0; m_last = 2; m_err = 1'b0;
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    end else begin
      acc  = f_mem_en() && !i_mem_in_use;
      ack  = f_ack();
      orph = i_mem_enable && !m_valid[i_mem_id_response];
      g    = m_gnt;
      rq   = int'(i_mem_id_request);
      rs   = int'(i_mem_id_response);
      if (ack) m_valid[rs] = 1'b0;
      if (acc) begin m_valid[rq] = 1'b1; m_owner[rq] = g; end
      if (orph) m_err = 1'b1;
      if (g == 0) begin
        if (ic_if.i_enable && dc_if.i_enable) m_gnt = (m_last == 1) ? 2 : 1;
        else if (ic_if.i_enable) m_gnt = 1;
        else if (dc_if.i_enable) m_gnt = 2;
      end else if (acc) begin
        m_last = g; m_gnt = 0;
      end else if (!side_en(g)) begin
        m_gnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mem_enable", o_mem_enable, f_mem_en());
      if (f_mem_en())
        chk("mem_addr", o_mem_addr, (m_gnt == 2) ? dc_if.i_addr : ic_if.i_addr);
      chk("ic_in_use", ic_if.o_in_use, f_in_use(1));
      chk("dc_in_use", dc_if.o_in_use, f_in_use(2));
      chk("ic_enable", ic_if.o_enable, f_route(1));
      chk("dc_enable", dc_if.o_enable, f_route(2));
      chk("mem_ack", o_mem_ack, f_ack());
      chk("outstanding", o_outstanding, f_count());
      chk("err_orphan", o_err_orphan, m_err);
      chk("ic_data", ic_if.o_data, i_mem_data);
      chk("dc_data", dc_if.o_data, i_mem_data);
      chk("dc_id_request", dc_if.o_id_request, i_mem_id_request);
      chk("ic_id_response", ic_if.o_id_response, i_mem_id_response);
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    ic_if.i_enable = 0; ic_if.i_addr = '0; ic_if.i_ack = 0;
    dc_if.i_enable = 0; dc_if.i_addr = '0; dc_if.i_ack = 0;
    i_mem_enable = 0; i_mem_data = '0; i_mem_id_request = '0;
    i_mem_id_response = '0; i_mem_in_use = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    nxt(); nxt();
    // Lone ica request at 0x100 given id 2.
    rst = 1'b0;
    ic_if.i_enable = 1; ic_if.i_addr = 32'h100; i_mem_id_request = 3'd2;
    @(negedge clk);
    chk("t1_cycle1_mem_en", o_mem_enable, 1'b0);
    chk("t1_cycle1_ic_in_use", ic_if.o_in_use, 1'b1);
    chk("t1_reset_count", o_outstanding, 4'd0);
    nxt(); @(negedge clk);
    chk("t1_cycle2_mem_en", o_mem_enable, 1'b1);
    chk("t1_cycle2_addr", o_mem_addr, 32'h100);
    chk("t1_cycle2_ic_in_use", ic_if.o_in_use, 1'b0);
    chk("t1_cycle2_dc_in_use", dc_if.o_in_use, 1'b1);
    // Response for id 2 back to ica.
    nxt();
    ic_if.i_enable = 0;
    i_mem_enable = 1; i_mem_id_response = 3'd2; ic_if.i_ack = 1;
    i_mem_data = {8{32'hA5A5A5A5}};
    @(negedge clk);
    chk("t1_count_after_accept", o_outstanding, 4'd1);
    chk("t3_ic_enable", ic_if.o_enable, 1'b1);
    chk("t3_dc_enable", dc_if.o_enable, 1'b0);
    chk("t3_mem_ack", o_mem_ack, 1'b1);
    chk("t3_ic_data", ic_if.o_data, {8{32'hA5A5A5A5}});
    // Orphan response on id 5.
    nxt();
    idle_in();
    i_mem_enable = 1; i_mem_id_response = 3'd5; ic_if.i_ack = 1; dc_if.i_ack = 1;
    @(negedge clk);
    chk("t3_count_cleared", o_outstanding, 4'd0);
    chk("t6_no_ic_enable", ic_if.o_enable, 1'b0);
    chk("t6_no_dc_enable", dc_if.o_enable, 1'b0);
    chk("t6_no_ack", o_mem_ack, 1'b0);
    nxt(); idle_in(); @(negedge clk);
    chk("t6_err_set", o_err_orphan, 1'b1);
    nxt(); @(negedge clk);
    chk("t6_err_sticky", o_err_orphan, 1'b1);
    // Tie out of reset: IC, then DC, then IC.
    nxt(); rst = 1'b1; @(negedge clk);
    chk("rst_ic_in_use", ic_if.o_in_use, 1'b1);
    chk("rst_dc_in_use", dc_if.o_in_use, 1'b1);
    nxt(); rst = 1'b0;
    ic_if.i_enable = 1; ic_if.i_addr = 32'h100;
    dc_if.i_enable = 1; dc_if.i_addr = 32'h200; i_mem_id_request = 3'd3;
    @(negedge clk);
    chk("t2_err_cleared", o_err_orphan, 1'b0);
    chk("t2_c0_mem_en", o_mem_enable, 1'b0);
    nxt(); @(negedge clk);
    chk("t2_c1_addr_ic", o_mem_addr, 32'h100);
    chk("t2_c1_mem_en", o_mem_enable, 1'b1);
    nxt(); i_mem_id_request = 3'd4; @(negedge clk);
    chk("t2_c2_mem_en", o_mem_enable, 1'b0);
    nxt(); @(negedge clk);
    chk("t2_c3_addr_dc", o_mem_addr, 32'h200);
    chk("t2_c3_dc_in_use", dc_if.o_in_use, 1'b0);
    nxt(); i_mem_id_request = 3'd5;
    nxt(); @(negedge clk);
    chk("t2_c5_addr_ic", o_mem_addr, 32'h100);
    nxt(); idle_in(); @(negedge clk);
    chk("t2_count3", o_outstanding, 4'd3);
    // Reset with three outstanding.
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; @(negedge clk);
    chk("t6_rst_count", o_outstanding, 4'd0);
    chk("t6_rst_ic_in_use", ic_if.o_in_use, 1'b1);
    chk("t6_rst_dc_in_use", dc_if.o_in_use, 1'b1);
    // Fill all eight IDs from ica, then a dca request must wait.
    for (int k = 0; k < 8; k++) begin
      nxt(); ic_if.i_enable = 1; ic_if.i_addr = 32'h1000 + k; i_mem_id_request = 3'(k);
      nxt();
    end
    nxt();
    ic_if.i_enable = 0; dc_if.i_enable = 1; dc_if.i_addr = 32'h300; i_mem_id_request = 3'd0;
    @(negedge clk);
    chk("t4_full_count", o_outstanding, 4'd8);
    for (int k = 0; k < 2; k++) begin
      nxt(); @(negedge clk);
      chk("t4_blocked_mem_en", o_mem_enable, 1'b0);
      chk("t4_blocked_dc_in_use", dc_if.o_in_use, 1'b1);
    end
    nxt(); i_mem_enable = 1; i_mem_id_response = 3'd0; ic_if.i_ack = 1; @(negedge clk);
    chk("t4_ack_cycle_ack", o_mem_ack, 1'b1);
    chk("t4_ack_cycle_mem_en", o_mem_enable, 1'b0);
    nxt(); i_mem_enable = 0; ic_if.i_ack = 0; @(negedge clk);
    chk("t4_after_ack_mem_en", o_mem_enable, 1'b1);
    chk("t4_after_ack_dc_in_use", dc_if.o_in_use, 1'b0);
    chk("t4_after_ack_count", o_outstanding, 4'd7);
    nxt(); idle_in(); @(negedge clk);
    chk("t4_refilled_count", o_outstanding, 4'd8);
    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      nxt();
      rst               = ($urandom_range(0, 199) == 0);
      ic_if.i_enable    = ($urandom_range(0, 3) != 0);
      dc_if.i_enable    = ($urandom_range(0, 3) != 0);
      ic_if.i_addr      = $urandom;
      dc_if.i_addr      = $urandom;
      ic_if.i_ack       = ($urandom_range(0, 4) != 0);
      dc_if.i_ack       = ($urandom_range(0, 4) != 0);
      i_mem_enable      = ($urandom_range(0, 1) != 0);
      i_mem_data        = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
      i_mem_id_request  = 3'($urandom_range(0, 7));
      i_mem_id_response = 3'($urandom_range(0, 7));
      i_mem_in_use      = ($urandom_range(0, 3) == 0);
    end
    nxt(); idle_in();
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
